cordic_vector_iter_16b: RTL and testbench

//  Iterative, handshaked CORDIC in vectoring mode: the inverse of the

---
 rtl/cordic_vector_iter_16b.sv | 150 +++++++++++++++
 tb/tb_cordic_vector_iter_16b.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_iter_16b.sv
// cordic_vector_iter_16b
//   Iterative CORDIC, vectoring mode. A vector is accepted on an
//   in_valid/in_ready handshake. The block then performs one micro-rotation
//   per clock, driving y toward 0 and accumulating the angle in z. It uses
//   the rotation-mode angle table and shift schedule. The final x/y/z are
//   registered and presented with out_valid until out_ready takes them.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     in_valid / in_ready  input handshake (in_ready high only when idle)
//     x_in, y_in, z_in     initial vector and angle accumulator
//     out_valid/out_ready  output handshake (out_valid high only when done)
//     x_out, y_out, z_out  final x (magnitude * gain), residual y, angle
//
//   The result takes ITERATIONS clocks after the accept edge.
//   Back-to-back vectors are accepted once every ITERATIONS+2 clocks.
//   All arithmetic wraps and no gain compensation is applied.

// One vectoring micro-rotation. x, y and z all update from the current values.
module cordic_vector_iter_16b_urot #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x_cur,
  input  logic signed [WIDTH-1:0] y_cur,
  input  logic signed [WIDTH-1:0] z_cur,
  input  logic        [3:0]       shift,
  output logic signed [WIDTH-1:0] x_nxt,
  output logic signed [WIDTH-1:0] y_nxt,
  output logic signed [WIDTH-1:0] z_nxt
);
  localparam logic [15:0] ANG_BASE = 16'h8000;

  logic signed [WIDTH-1:0] x_sh, y_sh;
  logic        [WIDTH-1:0] ang;

  assign x_sh = x_cur >>> shift;
  assign y_sh = y_cur >>> shift;
  // Binary angle table: 16'h8000 >> i. It is the same table as the rotator.
  assign ang  = WIDTH'(ANG_BASE >> shift);

  always_comb begin
    x_nxt = x_cur;
    y_nxt = y_cur;
    z_nxt = z_cur;
    // A y of exactly zero takes the non-negative branch.
    if (!y_cur[WIDTH-1]) begin
      x_nxt = x_cur + y_sh;
      y_nxt = y_cur - x_sh;
      z_nxt = z_cur + $signed(ang);
    end else begin
      x_nxt = x_cur - y_sh;
      y_nxt = y_cur + x_sh;
      z_nxt = z_cur - $signed(ang);
    end
  end
endmodule

module cordic_vector_iter_16b #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 12   // 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

  state_t                  state_q, state_d;
  logic [3:0]              iter_q;
  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
  logic                    accept, last_iter;

  assign accept    = in_valid & in_ready;
  assign last_iter = (iter_q == LAST_ITER);

  cordic_vector_iter_16b_urot #(.WIDTH(WIDTH)) u_urot (
    .x_cur (x_q),
    .y_cur (y_q),
    .z_cur (z_q),
    .shift (iter_q),
    .x_nxt (x_nx),
    .y_nxt (y_nx),
    .z_nxt (z_nx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      state_q   <= state_d;
      // The handshake flags are registered copies of the next state.
      // This keeps in_ready independent of out_ready.
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: if (accept) begin
          x_q    <= $signed(x_in);
          y_q    <= $signed(y_in);
          z_q    <= $signed(z_in);
          iter_q <= '0;
        end
        RUN: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          z_q    <= z_nx;
          iter_q <= iter_q + 4'd1;
          // Capture the final rotation directly into the output registers.
          // Earlier results stay visible until this edge.
          if (last_iter) begin
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_vector_iter_16b.sv
module tb_cordic_vector_iter_16b;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x_in, y_in, z_in, x_out, y_out, z_out;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [15:0] x_in4, y_in4, z_in4, x_out4, y_out4, z_out4;

  cordic_vector_iter_16b #(.WIDTH(16), .ITERATIONS(12)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_vector_iter_16b #(.WIDTH(16), .ITERATIONS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .x_in(x_in4), .y_in(y_in4), .z_in(z_in4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .x_out(x_out4), .y_out(y_out4), .z_out(z_out4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp4_q[$];
  bit   rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Bit-true reference of the vectoring equations.
  function automatic logic [47:0] model(input int n, input logic [15:0] x0, y0, z0);
    logic signed [15:0] x, y, z, xn, yn;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < n; i++) begin
      if (!y[15]) begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + (16'h8000 >> i);
      end else begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - (16'h8000 >> i);
      end
      x = xn; y = yn;
    end
    return {x, y, z};
  endfunction

  // Monitors: each result taken on a handshake is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual=%h required=none", {x_out, y_out, z_out});
      end else begin
        chk("result", {x_out, y_out, z_out}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (exp4_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output4 actual=%h required=none", {x_out4, y_out4, z_out4});
      end else begin
        chk("result_it4", {x_out4, y_out4, z_out4}, exp4_q.pop_front());
      end
    end
  end

  // out_ready driver: a held value, or random stalls.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // Holds in_valid until accepted. The caller drops in_valid afterwards.
  task automatic send(input logic [15:0] x, y, z, input logic [47:0] e,
                      input bit push, output int acc_cyc);
    in_valid = 1'b1; x_in = x; y_in = y; z_in = z;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=in_ready=0 required=1");
      in_valid = 1'b0; acc_cyc = -1;
      return;
    end
    if (push) exp_q.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk(name, 48'(exp_q.size()), 48'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    int acc_t[5];
    logic [47:0] snap;
    logic [15:0] rx, ry, rz;

    rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; x_in4 = '0; y_in4 = '0; z_in4 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset_in_ready", 48'(in_ready), 48'd1);
    chk("reset_out_valid", 48'(out_valid), 48'd0);
    chk("reset_outputs", {x_out, y_out, z_out}, 48'd0);
    chk("reset_in_ready4", 48'(in_ready4), 48'd1);

    // T2: ITER=4, x=1000 -> 1641, 78, 4096 with a latency of 4
    in_valid4 = 1'b1; x_in4 = 16'd1000; y_in4 = 16'd0; z_in4 = 16'd0;
    for (int t = 0; t < 20 && !in_ready4; t++) @(negedge clk);
    @(negedge clk);
    exp4_q.push_back({16'd1641, 16'd78, 16'd4096});
    @(posedge clk); #1 in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency_it4", 48'(n), 48'd4);
    repeat (3) @(posedge clk); #1;
    chk("drain_it4", 48'(exp4_q.size()), 48'd0);

    // T1: zero vector. y stays zero, so every step adds the angle: z = FFF0.
    rdy_val = 1'b1;
    @(posedge clk); #1;
    send(16'd0, 16'd0, 16'd0, {16'h0000, 16'h0000, 16'hFFF0}, 1'b1, acc);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency_it12", 48'(n), 48'd12);
    drain("drain_t1");

    // T3: a stalled output stays stable, and in_ready stays low.
    rdy_val = 1'b0;
    @(posedge clk); #1;
    send(16'd300, 16'd400, 16'd0, model(12, 16'd300, 16'd400, 16'd0), 1'b1, acc);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    snap = {x_out, y_out, z_out};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 48'(out_valid), 48'd1);
      chk("stall_data", {x_out, y_out, z_out}, snap);
      chk("stall_in_ready", 48'(in_ready), 48'd0);
    end
    rdy_val = 1'b1;
    drain("drain_t3");

    // T4: with in_valid held high, a vector is accepted every 14 cycles.
    for (int k = 0; k < 5; k++) begin
      rx = 16'(k * 1111 - 2000); ry = 16'(3000 - k * 1733); rz = 16'(k * 257);
      send(rx, ry, rz, model(12, rx, ry, rz), 1'b1, acc_t[k]);
    end
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) chk("b2b_interval", 48'(acc_t[k] - acc_t[k-1]), 48'd14);
    drain("drain_t4");

    // Directed corner vectors: wraparound and negative y.
    send(16'h7FFF, 16'h7FFF, 16'h0000, model(12, 16'h7FFF, 16'h7FFF, 16'h0000), 1'b1, acc);
    send(16'h8000, 16'hFFFF, 16'h1234, model(12, 16'h8000, 16'hFFFF, 16'h1234), 1'b1, acc);
    in_valid = 1'b0;
    drain("drain_corner");

    // T5: a reset mid-run discards the vector.
    send(16'd5000, 16'hF000, 16'd0, 48'd0, 1'b0, acc);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", 48'(in_ready), 48'd1);
    chk("midrst_out_valid", 48'(out_valid), 48'd0);
    chk("midrst_outputs", {x_out, y_out, z_out}, 48'd0);
    send(16'd1234, 16'd567, 16'd89, model(12, 16'd1234, 16'd567, 16'd89), 1'b1, acc);
    in_valid = 1'b0;
    drain("drain_t5");

    // T6: random vectors with random valid/ready stalls.
    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
      send(rx, ry, rz, model(12, rx, ry, rz), 1'b1, acc);
      in_valid = 1'b0;
    end
    drain("drain_t6");
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
